// File: rtl/apb_to_axi_lite.sv
// APB4 completer that issues one AXI4-Lite master transaction per APB transfer.
// A single transaction is in flight; pready is held low until the AXI response returns.
`timescale 1ns/1ps
module apb_to_axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // APB completer
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [2:0]            aw_prot,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  // AXI4-Lite write response
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [2:0]            ar_prot,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0] state;
  logic       aw_done;
  logic       w_done;
  logic       setup;
  logic       aw_done_nxt;
  logic       w_done_nxt;
  logic       unused_resp;

  assign setup       = psel & ~penable;
  assign aw_done_nxt = aw_done | (aw_valid & aw_ready);
  assign w_done_nxt  = w_done  | (w_valid  & w_ready);

  // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp = b_resp[0] ^ r_resp[0];

  // Reset is active-high despite the legacy rst_n name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      aw_addr  <= '0;
      aw_prot  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      ar_addr  <= '0;
      ar_prot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            if (pwrite) begin
              aw_addr  <= paddr;
              aw_prot  <= pprot;
              w_data   <= pwdata;
              w_strb   <= pstrb;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
              state    <= WR_REQ;
            end else begin
              ar_addr  <= paddr;
              ar_prot  <= pprot;
              ar_valid <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // Each channel drops its valid independently once accepted.
          aw_valid <= aw_valid & ~aw_ready;
          w_valid  <= w_valid  & ~w_ready;
          aw_done  <= aw_done_nxt;
          w_done   <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            b_ready <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            pslverr <= b_resp[1];
            prdata  <= '0;
            pready  <= 1'b1;
            state   <= DONE;
          end
        end
        RD_REQ: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_valid) begin
            r_ready <= 1'b0;
            prdata  <= r_data;
            pslverr <= r_resp[1];
            pready  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_to_axi_lite.sv
// Bench for apb_to_axi_lite: APB requester tasks, reactive AXI-Lite completer
// processes and a queue-based scoreboard on both the AXI and APB sides.
`timescale 1ns/1ps
module tb_apb_to_axi_lite;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } apb_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0]  aw_prot, ar_prot;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;

  int errors = 0;
  int checks = 0;

  axi_t     aw_q[$];
  axi_t     w_q[$];
  axi_t     ar_q[$];
  apb_exp_t apb_q[$];
  rd_rsp_t  rd_rsp_q[$];
  logic [1:0] wr_rsp_q[$];

  int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit  rand_mode = 1'b0;
  bit  b_hold = 1'b0;
  int  aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, ar_valid_cycles = 0;

  always #5 clk = ~clk;

  apb_to_axi_lite dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  // AXI completer: each channel reacts on the falling edge with a programmable delay.
  initial begin : aw_slave
    int n;
    aw_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (aw_valid) begin
        n = rand_mode ? int'($urandom_range(0, 3)) : aw_dly;
        repeat (n) @(negedge clk);
        aw_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0;
      end
    end
  end

  initial begin : w_slave
    int n;
    w_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (w_valid) begin
        n = rand_mode ? int'($urandom_range(0, 3)) : w_dly;
        repeat (n) @(negedge clk);
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
      end
    end
  end

  initial begin : ar_slave
    int n;
    ar_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ar_valid) begin
        n = rand_mode ? int'($urandom_range(0, 3)) : ar_dly;
        repeat (n) @(negedge clk);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
      end
    end
  end

  initial begin : b_slave
    int n;
    b_valid = 1'b0;
    b_resp  = 2'b00;
    forever begin
      @(negedge clk);
      if (b_ready) begin
        n = rand_mode ? int'($urandom_range(0, 3)) : b_dly;
        while (n > 0 || b_hold) begin
          @(negedge clk);
          if (!b_hold && n > 0) n--;
        end
        if (b_ready && wr_rsp_q.size() > 0) begin
          b_valid = 1'b1;
          b_resp  = wr_rsp_q.pop_front();
          @(negedge clk);
          b_valid = 1'b0;
          b_resp  = 2'b00;
        end
      end
    end
  end

  initial begin : r_slave
    int n;
    rd_rsp_t rsp;
    r_valid = 1'b0;
    r_data  = '0;
    r_resp  = 2'b00;
    forever begin
      @(negedge clk);
      if (r_ready) begin
        n = rand_mode ? int'($urandom_range(0, 3)) : r_dly;
        repeat (n) @(negedge clk);
        if (r_ready && rd_rsp_q.size() > 0) begin
          rsp     = rd_rsp_q.pop_front();
          r_valid = 1'b1;
          r_data  = rsp.data;
          r_resp  = rsp.resp;
          @(negedge clk);
          r_valid = 1'b0;
          r_data  = '0;
          r_resp  = 2'b00;
        end
      end
    end
  end

  // Protocol and scoreboard monitor, sampling mid-cycle.
  initial begin : monitor
    axi_t     e;
    apb_exp_t a;
    bit p_aw_pend, p_w_pend, p_ar_pend, p_pready;
    logic [31:0] p_aw_addr, p_w_data, p_ar_addr;
    logic [2:0]  p_aw_prot, p_ar_prot;
    logic [3:0]  p_w_strb;
    p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0; p_pready = 0;
    p_aw_addr = '0; p_w_data = '0; p_ar_addr = '0;
    p_aw_prot = '0; p_ar_prot = '0; p_w_strb = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0; p_pready = 0;
      end else begin
        if (p_aw_pend) begin
          checks++;
          if (aw_valid !== 1'b1 || aw_addr !== p_aw_addr || aw_prot !== p_aw_prot) begin
            errors++;
            $display("FAIL aw_hold: got valid=%b addr=%h prot=%h, need valid=1 addr=%h prot=%h",
                     aw_valid, aw_addr, aw_prot, p_aw_addr, p_aw_prot);
          end
        end
        if (p_w_pend) begin
          checks++;
          if (w_valid !== 1'b1 || w_data !== p_w_data || w_strb !== p_w_strb) begin
            errors++;
            $display("FAIL w_hold: got valid=%b data=%h strb=%h, need valid=1 data=%h strb=%h",
                     w_valid, w_data, w_strb, p_w_data, p_w_strb);
          end
        end
        if (p_ar_pend) begin
          checks++;
          if (ar_valid !== 1'b1 || ar_addr !== p_ar_addr || ar_prot !== p_ar_prot) begin
            errors++;
            $display("FAIL ar_hold: got valid=%b addr=%h prot=%h, need valid=1 addr=%h prot=%h",
                     ar_valid, ar_addr, ar_prot, p_ar_addr, p_ar_prot);
          end
        end
        if (aw_valid && aw_ready) begin
          aw_hs_cnt++;
          checks++;
          if (aw_q.size() == 0) begin
            errors++;
            $display("FAIL aw_extra: got handshake addr=%h, need none", aw_addr);
          end else begin
            e = aw_q.pop_front();
            if (aw_addr !== e.addr || aw_prot !== e.prot) begin
              errors++;
              $display("FAIL aw_payload: got addr=%h prot=%h, need addr=%h prot=%h",
                       aw_addr, aw_prot, e.addr, e.prot);
            end
          end
        end
        if (w_valid && w_ready) begin
          w_hs_cnt++;
          checks++;
          if (w_q.size() == 0) begin
            errors++;
            $display("FAIL w_extra: got handshake data=%h, need none", w_data);
          end else begin
            e = w_q.pop_front();
            if (w_data !== e.data || w_strb !== e.strb) begin
              errors++;
              $display("FAIL w_payload: got data=%h strb=%h, need data=%h strb=%h",
                       w_data, w_strb, e.data, e.strb);
            end
          end
        end
        if (ar_valid) ar_valid_cycles++;
        if (ar_valid && ar_ready) begin
          ar_hs_cnt++;
          checks++;
          if (ar_q.size() == 0) begin
            errors++;
            $display("FAIL ar_extra: got handshake addr=%h, need none", ar_addr);
          end else begin
            e = ar_q.pop_front();
            if (ar_addr !== e.addr || ar_prot !== e.prot) begin
              errors++;
              $display("FAIL ar_payload: got addr=%h prot=%h, need addr=%h prot=%h",
                       ar_addr, ar_prot, e.addr, e.prot);
            end
          end
        end
        if (b_ready) begin
          checks++;
          if (aw_q.size() != 0 || w_q.size() != 0 || aw_valid || w_valid) begin
            errors++;
            $display("FAIL b_early: got b_ready with aw_pending=%0d w_pending=%0d, need both done",
                     aw_q.size(), w_q.size());
          end
        end
        if (pready) begin
          checks++;
          if (p_pready) begin
            errors++;
            $display("FAIL pready_width: got pready high two cycles, need one");
          end
          checks++;
          if (apb_q.size() == 0) begin
            errors++;
            $display("FAIL pready_extra: got pready with prdata=%h, need none", prdata);
          end else begin
            a = apb_q.pop_front();
            if (prdata !== a.data || pslverr !== a.err) begin
              errors++;
              $display("FAIL apb_resp: got prdata=%h pslverr=%b, need prdata=%h pslverr=%b",
                       prdata, pslverr, a.data, a.err);
            end
          end
        end else begin
          checks++;
          if (prdata !== 32'h0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp: got prdata=%h pslverr=%b without pready, need 0/0",
                     prdata, pslverr);
          end
        end
        p_aw_pend = aw_valid && !aw_ready; p_aw_addr = aw_addr; p_aw_prot = aw_prot;
        p_w_pend  = w_valid  && !w_ready;  p_w_data  = w_data;  p_w_strb  = w_strb;
        p_ar_pend = ar_valid && !ar_ready; p_ar_addr = ar_addr; p_ar_prot = ar_prot;
        p_pready  = pready;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One APB transfer; expectations are queued before the setup phase is driven.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] rd, input logic [1:0] resp, output int cyc);
    if (wr) begin
      aw_q.push_back('{addr: addr, prot: prot, data: 32'h0, strb: 4'h0});
      w_q.push_back('{addr: 32'h0, prot: 3'h0, data: wd, strb: st});
      wr_rsp_q.push_back(resp);
      apb_q.push_back('{data: 32'h0, err: resp[1]});
    end else begin
      ar_q.push_back('{addr: addr, prot: prot, data: 32'h0, strb: 4'h0});
      rd_rsp_q.push_back('{data: rd, resp: resp});
      apb_q.push_back('{data: rd, err: resp[1]});
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pprot = prot;
    pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0;
    while (!pready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL apb_timeout: got no pready after %0d cycles, need pready", cyc);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr} !== 7'b0 ||
        prdata !== 32'h0 || aw_addr !== 32'h0 || w_data !== 32'h0 || w_strb !== 4'h0 ||
        ar_addr !== 32'h0 || aw_prot !== 3'h0 || ar_prot !== 3'h0) begin
      errors++;
      $display("FAIL reset_state: got ctrl=%b prdata=%h aw=%h w=%h ar=%h, need all 0",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr},
               prdata, aw_addr, w_data, ar_addr);
    end
    rst_n = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_write;
    int cyc, aw0, w0;
    aw_dly = 0; w_dly = 0; b_dly = 0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    apb_xfer(1'b1, 32'h0000_1000, 3'b010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL write_latency: got pready at access cycle %0d, need 3", cyc + 1);
    end
    checks++;
    if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL write_hs_count: got aw=%0d w=%0d, need 1 and 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    idle(1);
  endtask

  task automatic test_read_delayed;
    int cyc, v0;
    ar_dly = 4; r_dly = 0;
    v0 = ar_valid_cycles;
    apb_xfer(1'b0, 32'h0000_2004, 3'b101, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, cyc);
    checks++;
    if (ar_valid_cycles - v0 !== 5) begin
      errors++;
      $display("FAIL ar_valid_len: got %0d cycles, need 5", ar_valid_cycles - v0);
    end
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL read_latency: got pready at access cycle %0d, need 7", cyc + 1);
    end
    ar_dly = 0;
    idle(1);
  endtask

  task automatic test_write_order;
    int cyc, aw0, w0;
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 0 : 3;
      w_dly  = (k == 0) ? 3 : 0;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      apb_xfer(1'b1, 32'h0000_3000 + k * 4, 3'b001, 32'h1234_0000 + k, 4'h5, 32'h0, 2'b00, cyc);
      checks++;
      if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
        errors++;
        $display("FAIL order_hs_count[%0d]: got aw=%0d w=%0d, need 1 and 1", k, aw_hs_cnt - aw0, w_hs_cnt - w0);
      end
      checks++;
      if (cyc !== 5) begin
        errors++;
        $display("FAIL order_latency[%0d]: got access cycle %0d, need 6", k, cyc + 1);
      end
      idle(1);
    end
    aw_dly = 0; w_dly = 0;
  endtask

  task automatic test_back_to_back;
    int c0, c1, c2;
    apb_xfer(1'b0, 32'h0000_4000, 3'b000, 32'h0, 4'h0, 32'h1111_2222, 2'b00, c0);
    apb_xfer(1'b1, 32'h0000_4008, 3'b011, 32'h5555_AAAA, 4'h3, 32'h0, 2'b11, c1);
    apb_xfer(1'b0, 32'h0000_400C, 3'b100, 32'h0, 4'h0, 32'h3333_4444, 2'b01, c2);
    checks++;
    if (c0 !== 2 || c1 !== 2 || c2 !== 2) begin
      errors++;
      $display("FAIL b2b_latency: got %0d/%0d/%0d, need 2/2/2", c0, c1, c2);
    end
    idle(1);
  endtask

  task automatic test_psel_drop;
    int cyc;
    aw_q.push_back('{addr: 32'h0000_5000, prot: 3'b111, data: 32'h0, strb: 4'h0});
    w_q.push_back('{addr: 32'h0, prot: 3'h0, data: 32'h0BAD_CAFE, strb: 4'hC});
    wr_rsp_q.push_back(2'b00);
    apb_q.push_back('{data: 32'h0, err: 1'b0});
    b_dly = 3;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_5000; pprot = 3'b111;
    pwdata = 32'h0BAD_CAFE; pstrb = 4'hC;
    idle(1);
    penable = 1;
    idle(1);
    psel = 0; penable = 0;
    cyc = 0;
    while (!pready && cyc < 50) begin idle(1); cyc++; end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL psel_drop_done: got no pready after %0d cycles, need one pulse", cyc);
    end
    b_dly = 0;
    idle(2);
  endtask

  task automatic test_reset_mid;
    int cyc;
    b_hold = 1'b1;
    aw_q.push_back('{addr: 32'h0000_6000, prot: 3'b010, data: 32'h0, strb: 4'h0});
    w_q.push_back('{addr: 32'h0, prot: 3'h0, data: 32'h7777_8888, strb: 4'hF});
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_6000; pprot = 3'b010;
    pwdata = 32'h7777_8888; pstrb = 4'hF;
    idle(1);
    penable = 1;
    cyc = 0;
    while (!b_ready && cyc < 20) begin idle(1); cyc++; end
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach: got b_ready=%b, need 1", b_ready);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr} !== 7'b0 ||
        prdata !== 32'h0 || aw_addr !== 32'h0 || w_data !== 32'h0 || w_strb !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got ctrl=%b prdata=%h aw=%h w=%h, need all 0",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr},
               prdata, aw_addr, w_data);
    end
    psel = 0; penable = 0;
    idle(2);
    b_hold = 1'b0;
    rst_n = 1'b0;
    idle(1);
    apb_xfer(1'b0, 32'h0000_6010, 3'b001, 32'h0, 4'h0, 32'h9ABC_DEF0, 2'b00, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL reset_mid_read: got access cycle %0d, need 3", cyc + 1);
    end
    idle(1);
  endtask

  task automatic test_random;
    int cyc;
    bit wr;
    rand_mode = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      wr = 1'($urandom_range(0, 1));
      apb_xfer(wr, $urandom, 3'($urandom), $urandom, 4'($urandom), $urandom, 2'($urandom), cyc);
      idle(int'($urandom_range(0, 1)));
    end
    rand_mode = 1'b0;
    idle(3);
  endtask

  task automatic test_drain;
    checks++;
    if (aw_q.size() != 0 || w_q.size() != 0 || ar_q.size() != 0 || apb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending aw=%0d w=%0d ar=%0d apb=%0d, need all 0",
               aw_q.size(), w_q.size(), ar_q.size(), apb_q.size());
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_basic_write();
    test_read_delayed();
    test_write_order();
    test_back_to_back();
    test_psel_drop();
    test_reset_mid();
    test_random();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
